// File: rtl/srl_64_iter.sv
// Iterative right shifter, logical or arithmetic, one bit position per clock.
// It pulses done once the result is ready and reports the guard bits that were shifted out.
module srl_64_iter #(
    parameter int unsigned WIDTH   = 64,
    parameter int unsigned SHAMT_W = 6
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               arith,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   out_data,
    output logic               last_out,
    output logic               sticky
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [SHAMT_W-1:0] cnt;
    logic               fill;
    logic               accept;
    logic               step;
    logic               finish;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt != '0) begin
                    step = 1'b1;
                end else begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The fill bit is frozen at accept, so later changes to arith or in_data cannot disturb a running op.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_data <= '0;
            cnt      <= '0;
            fill     <= 1'b0;
            last_out <= 1'b0;
            sticky   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= finish;
            if (accept) begin
                out_data <= in_data;
                cnt      <= shamt;
                fill     <= arith & in_data[WIDTH-1];
                last_out <= 1'b0;
                sticky   <= 1'b0;
                busy     <= 1'b1;
            end else if (step) begin
                out_data <= {fill, out_data[WIDTH-1:1]};
                last_out <= out_data[0];
                sticky   <= sticky | out_data[0];
                cnt      <= cnt - SHAMT_W'(1);
            end else if (finish) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_srl_64_iter.sv
// Scoreboard bench for srl_64_iter: the stimulus side queues the expected results and a monitor checks each done pulse.
module tb_srl_64_iter;

    localparam int unsigned WIDTH   = 64;
    localparam int unsigned SHAMT_W = 6;

    typedef struct {
        logic [WIDTH-1:0] out;
        logic             last;
        logic             stk;
        int               cyc;
    } exp_t;

    logic               clock;
    logic               reset_n;
    logic               start;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] shamt;
    logic               arith;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   out_data;
    logic               last_out;
    logic               sticky;

    exp_t exp_q[$];
    int   cyc        = 0;
    int   compared   = 0;
    int   mismatched = 0;

    srl_64_iter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .in_data (in_data),
        .shamt   (shamt),
        .arith   (arith),
        .busy    (busy),
        .done    (done),
        .out_data(out_data),
        .last_out(last_out),
        .sticky  (sticky)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called just after an edge has been passed: the request is taken at the next edge
    task automatic issue(input logic [WIDTH-1:0] d, input logic [SHAMT_W-1:0] s, input logic a,
                         input logic [WIDTH-1:0] eo, input logic el, input logic es);
        exp_t e;
        start   = 1'b1;
        in_data = d;
        shamt   = s;
        arith   = a;
        e.out   = eo;
        e.last  = el;
        e.stk   = es;
        e.cyc   = cyc + int'(s) + 2;
        exp_q.push_back(e);
    endtask

    task automatic drop_start();
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            #1;
            if (!busy && !done && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            compared++;
            mismatched++;
            $display("FAIL %s_timeout: got busy=%0b pending=%0d expected idle", name, busy, exp_q.size());
        end
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_out"},    out_data, '0);
        chk({name, "_busy"},   {63'd0, busy}, '0);
        chk({name, "_done"},   {63'd0, done}, '0);
        chk({name, "_last"},   {63'd0, last_out}, '0);
        chk({name, "_sticky"}, {63'd0, sticky}, '0);
    endtask

    // Monitor
    always @(negedge clock) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pulse", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_data", out_data, e.out);
                chk("last_out", {63'd0, last_out}, {63'd0, e.last});
                chk("sticky",   {63'd0, sticky},   {63'd0, e.stk});
                chk("latency",  WIDTH'(cyc), WIDTH'(e.cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        in_data = '0;
        shamt   = '0;
        arith   = 1'b0;
        repeat (3) @(negedge clock);
        chk_reset_outputs("reset");
        reset_n = 1'b1;

        // SRL by 1
        @(negedge clock);
        issue(64'h8000_0000_0000_0001, 6'd1, 1'b0, 64'h4000_0000_0000_0000, 1'b1, 1'b1);
        drop_start();
        wait_idle("srl1");

        // SRA full width; busy is probed mid-op
        @(negedge clock);
        issue(64'h8000_0000_0000_0000, 6'd63, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        drop_start();
        repeat (30) @(negedge clock);
        chk("sra63_busy", {63'd0, busy}, 64'd1);
        wait_idle("sra63");

        // Zero shift
        @(negedge clock);
        issue(64'h0123_4567_89AB_CDEF, 6'd0, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0);
        drop_start();
        wait_idle("zero");

        // Logical shift of a negative operand; in_data/arith change mid-op
        @(negedge clock);
        issue(64'h8000_0000_0000_0000, 6'd63, 1'b0, 64'h0000_0000_0000_0001, 1'b0, 1'b0);
        drop_start();
        in_data = '1;
        arith   = 1'b1;
        wait_idle("srl63");

        // Arithmetic, negative with guard bits
        @(negedge clock);
        issue(64'hF000_0000_0000_00FF, 6'd8, 1'b1, 64'hFFF0_0000_0000_0000, 1'b1, 1'b1);
        drop_start();
        wait_idle("sra8neg");

        // Arithmetic, positive operand
        @(negedge clock);
        issue(64'h7000_0000_0000_0000, 6'd4, 1'b1, 64'h0700_0000_0000_0000, 1'b0, 1'b0);
        drop_start();
        wait_idle("sra4pos");

        // Handshake: start while busy ignored, start on the done cycle accepted
        @(negedge clock);
        issue(64'hF0, 6'd4, 1'b0, 64'h0F, 1'b0, 1'b0);
        @(negedge clock);
        in_data = 64'hFF;
        shamt   = 6'd1;
        drop_start();
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 50; i++) begin
                if (done) begin
                    seen = 1'b1;
                    break;
                end
                @(negedge clock);
            end
            if (!seen) begin
                compared++;
                mismatched++;
                $display("FAIL hs_done_timeout: got no done expected done");
            end
        end
        issue(64'h3, 6'd1, 1'b0, 64'h1, 1'b1, 1'b1);
        drop_start();
        wait_idle("handshake");

        // Abort with reset mid-op
        @(negedge clock);
        start   = 1'b1;
        in_data = 64'hDEAD_BEEF_CAFE_F00D;
        shamt   = 6'd40;
        arith   = 1'b1;
        drop_start();
        repeat (10) @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("abort_now");
        repeat (3) @(negedge clock);
        chk_reset_outputs("abort_hold");
        reset_n = 1'b1;
        repeat (50) @(negedge clock);
        chk("abort_no_done_busy", {63'd0, busy}, '0);

        @(negedge clock);
        issue(64'h100, 6'd8, 1'b0, 64'h1, 1'b0, 1'b0);
        drop_start();
        wait_idle("post_abort");

        repeat (5) @(negedge clock);
        chk("pending_expectations", WIDTH'(exp_q.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
